// File: rtl/pipe_pkg.sv
// Shared definitions for the 8-bit Harvard pipeline control blocks.
package pipe_pkg;

    localparam int REG_W = 2;

    localparam logic [7:0] INT_VECTOR_ADDR = 8'h04;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        INT_DRAIN = 2'd1,
        INT_PUSH  = 2'd2,
        INT_VEC   = 2'd3
    } hz_state_t;

endpackage

// File: rtl/load_use_detect.sv
// Flags a load in ID/EX whose destination is read by the instruction in IF/ID.
module load_use_detect
    import pipe_pkg::*;
(
    input  logic             idex_mem_read,
    input  logic [REG_W-1:0] idex_rd,
    input  logic [REG_W-1:0] ifid_rs_a,
    input  logic [REG_W-1:0] ifid_rs_b,
    input  logic             ifid_uses_a,
    input  logic             ifid_uses_b,
    output logic             load_use
);

    assign load_use = idex_mem_read &
                      ((ifid_uses_a & (ifid_rs_a == idex_rd)) |
                       (ifid_uses_b & (ifid_rs_b == idex_rd)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer: load-use stalls, branch flushes and interrupt entry
// (drain, PC push, vector load).
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int DRAIN_CYCLES = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             idex_mem_read,
    input  logic [REG_W-1:0] idex_rd,
    input  logic [REG_W-1:0] ifid_rs_a,
    input  logic [REG_W-1:0] ifid_rs_b,
    input  logic             ifid_uses_a,
    input  logic             ifid_uses_b,
    input  logic             ex_branch_taken,
    input  logic             irq,
    input  logic             int_enable,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             memwb_flush,
    output logic             push_pc,
    output logic             load_vector,
    output logic             int_active
);

    localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYCLES - 1);

    hz_state_t  state, state_next;
    logic [2:0] drain_cnt, drain_cnt_next;
    logic       irq_pending, irq_pending_next;
    logic       load_use;

    load_use_detect u_load_use_detect (
        .idex_mem_read (idex_mem_read),
        .idex_rd       (idex_rd),
        .ifid_rs_a     (ifid_rs_a),
        .ifid_rs_b     (ifid_rs_b),
        .ifid_uses_a   (ifid_uses_a),
        .ifid_uses_b   (ifid_uses_b),
        .load_use      (load_use)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            drain_cnt   <= 3'd0;
            irq_pending <= 1'b0;
        end else begin
            state       <= state_next;
            drain_cnt   <= drain_cnt_next;
            irq_pending <= irq_pending_next;
        end
    end

    always_comb begin
        state_next     = state;
        drain_cnt_next = drain_cnt;
        case (state)
            RUN: begin
                if (irq_pending && int_enable && !ex_branch_taken && !load_use) begin
                    state_next     = INT_DRAIN;
                    drain_cnt_next = DRAIN_LOAD;
                end
            end
            INT_DRAIN: begin
                if (drain_cnt == 3'd0) state_next = INT_PUSH;
                else                   drain_cnt_next = drain_cnt - 3'd1;
            end
            INT_PUSH: state_next = INT_VEC;
            INT_VEC:  state_next = RUN;
            default:  state_next = RUN;
        endcase
        // Entering INT_PUSH consumes the request; this clear beats a new irq.
        irq_pending_next = (irq_pending | irq) &
                           !((state == INT_DRAIN) && (state_next == INT_PUSH));
    end

    always_comb begin
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        push_pc     = 1'b0;
        load_vector = 1'b0;
        int_active  = 1'b0;
        if (!reset) begin
            case (state)
                RUN: begin
                    // A taken branch squashes the wrong-path load-use consumer.
                    if (ex_branch_taken) begin
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end else if (load_use) begin
                        pc_stall   = 1'b1;
                        ifid_stall = 1'b1;
                        idex_flush = 1'b1;
                    end
                end
                INT_DRAIN: begin
                    pc_stall   = 1'b1;
                    ifid_flush = 1'b1;
                    int_active = 1'b1;
                    idex_flush = ex_branch_taken;
                end
                INT_PUSH: begin
                    push_pc    = 1'b1;
                    pc_stall   = 1'b1;
                    ifid_flush = 1'b1;
                    int_active = 1'b1;
                end
                INT_VEC: begin
                    load_vector = 1'b1;
                    ifid_flush  = 1'b1;
                    int_active  = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with DRAIN_CYCLES=3.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       idex_mem_read;
    logic [1:0] idex_rd, ifid_rs_a, ifid_rs_b;
    logic       ifid_uses_a, ifid_uses_b;
    logic       ex_branch_taken, irq, int_enable;
    logic       pc_stall, ifid_stall, ifid_flush, idex_flush;
    logic       exmem_flush, memwb_flush, push_pc, load_vector, int_active;
    logic [8:0] outs;

    int n_cmp = 0;
    int n_err = 0;

    // Output vector order: pc_stall ifid_stall ifid_flush idex_flush
    // exmem_flush memwb_flush push_pc load_vector int_active
    localparam logic [8:0] O_IDLE  = 9'b000000000;
    localparam logic [8:0] O_LU    = 9'b110100000;
    localparam logic [8:0] O_BR    = 9'b001100000;
    localparam logic [8:0] O_DRAIN = 9'b101000001;
    localparam logic [8:0] O_DRBR  = 9'b101100001;
    localparam logic [8:0] O_PUSH  = 9'b101000101;
    localparam logic [8:0] O_VEC   = 9'b001000011;

    always #5 clk = ~clk;

    assign outs = {pc_stall, ifid_stall, ifid_flush, idex_flush,
                   exmem_flush, memwb_flush, push_pc, load_vector, int_active};

    pipe_hazard_ctrl #(.DRAIN_CYCLES(3)) dut (
        .clk             (clk),
        .reset           (reset),
        .idex_mem_read   (idex_mem_read),
        .idex_rd         (idex_rd),
        .ifid_rs_a       (ifid_rs_a),
        .ifid_rs_b       (ifid_rs_b),
        .ifid_uses_a     (ifid_uses_a),
        .ifid_uses_b     (ifid_uses_b),
        .ex_branch_taken (ex_branch_taken),
        .irq             (irq),
        .int_enable      (int_enable),
        .pc_stall        (pc_stall),
        .ifid_stall      (ifid_stall),
        .ifid_flush      (ifid_flush),
        .idex_flush      (idex_flush),
        .exmem_flush     (exmem_flush),
        .memwb_flush     (memwb_flush),
        .push_pc         (push_pc),
        .load_vector     (load_vector),
        .int_active      (int_active)
    );

    task automatic check_eq(input string tag, input logic [8:0] got, input logic [8:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle_check(input string tag, input logic [8:0] exp);
        #2;
        check_eq(tag, outs, exp);
    endtask

    task automatic set_lu(input logic rd, input logic [1:0] r, input logic [1:0] a,
                          input logic [1:0] b, input logic ua, input logic ub);
        idex_mem_read = rd;
        idex_rd       = r;
        ifid_rs_a     = a;
        ifid_rs_b     = b;
        ifid_uses_a   = ua;
        ifid_uses_b   = ub;
    endtask

    initial begin
        reset = 1'b1;
        set_lu(1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
        ex_branch_taken = 1'b0;
        irq = 1'b0;
        int_enable = 1'b0;
        repeat (2) step();

        // Outputs gated off while reset is high, even with a hazard and irq present
        set_lu(1'b1, 2'd2, 2'd2, 2'd0, 1'b1, 1'b0);
        irq = 1'b1;
        int_enable = 1'b1;
        settle_check("reset_outs", O_IDLE);

        step();
        reset = 1'b0;
        irq = 1'b0;
        set_lu(1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
        settle_check("post_reset", O_IDLE);
        step();
        settle_check("no_pending_after_reset", O_IDLE);
        step();
        settle_check("still_run", O_IDLE);

        // Load-use on source A for one cycle
        set_lu(1'b1, 2'd2, 2'd2, 2'd0, 1'b1, 1'b0);
        settle_check("load_use_a", O_LU);
        step();
        set_lu(1'b0, 2'd2, 2'd2, 2'd0, 1'b1, 1'b0);
        settle_check("load_use_released", O_IDLE);

        step();
        set_lu(1'b1, 2'd1, 2'd3, 2'd1, 1'b0, 1'b1);
        settle_check("load_use_b", O_LU);
        step();
        set_lu(1'b1, 2'd3, 2'd2, 2'd1, 1'b1, 1'b1);
        settle_check("rd_mismatch", O_IDLE);
        step();
        set_lu(1'b1, 2'd2, 2'd2, 2'd2, 1'b0, 1'b0);
        settle_check("no_uses", O_IDLE);

        // Taken branch wins over a wrong-path load-use
        step();
        set_lu(1'b1, 2'd2, 2'd2, 2'd0, 1'b1, 1'b0);
        ex_branch_taken = 1'b1;
        settle_check("branch_over_lu", O_BR);
        step();
        ex_branch_taken = 1'b0;
        set_lu(1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
        settle_check("branch_done", O_IDLE);

        // Interrupt entry from a one-cycle irq pulse
        step();
        irq = 1'b1;
        settle_check("irq_seen", O_IDLE);
        step();
        irq = 1'b0;
        settle_check("irq_pending_run", O_IDLE);
        step();
        settle_check("drain1", O_DRAIN);
        step();
        ex_branch_taken = 1'b1;
        settle_check("drain2_branch", O_DRBR);
        step();
        ex_branch_taken = 1'b0;
        settle_check("drain3", O_DRAIN);
        step();
        settle_check("push", O_PUSH);
        step();
        irq = 1'b1;
        int_enable = 1'b0;
        settle_check("vector", O_VEC);
        step();
        settle_check("back_to_run", O_IDLE);

        // Masked: irq held with int_enable low keeps RUN
        for (int i = 0; i < 10; i++) begin
            step();
            settle_check("masked", O_IDLE);
        end

        // Enable while a load-use is present: the stall takes priority
        step();
        irq = 1'b0;
        int_enable = 1'b1;
        set_lu(1'b1, 2'd2, 2'd2, 2'd0, 1'b1, 1'b0);
        settle_check("enable_vs_lu", O_LU);
        step();
        set_lu(1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
        settle_check("enable_run", O_IDLE);
        step();
        settle_check("drain1_b", O_DRAIN);
        step();
        settle_check("drain2_b", O_DRAIN);
        step();
        settle_check("drain3_b", O_DRAIN);
        step();
        settle_check("push_b", O_PUSH);

        // Reset during INT_PUSH aborts the sequence
        reset = 1'b1;
        settle_check("reset_in_push", O_IDLE);
        step();
        settle_check("reset_held", O_IDLE);
        step();
        reset = 1'b0;
        settle_check("after_abort", O_IDLE);
        for (int i = 0; i < 4; i++) begin
            step();
            settle_check("no_vector", O_IDLE);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 8-bit Harvard pipeline (IF, ID, EX, MEM, WB). It detects load-use hazards and taken branches, and drives stall and flush controls into the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It also sequences interrupt entry: drain, PC push, vector load.

Parameters:
DRAIN_CYCLES, 3, cycles spent in INT_DRAIN so in-flight instructions retire before the PC push (1..7)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high; clock clk
idex_mem_read  in  1  instruction in ID/EX is a load
idex_rd  in  2  destination register of the ID/EX instruction
ifid_rs_a  in  2  source A of the IF/ID instruction
ifid_rs_b  in  2  source B of the IF/ID instruction
ifid_uses_a  in  1  IF/ID instruction reads rs_a
ifid_uses_b  in  1  IF/ID instruction reads rs_b
ex_branch_taken  in  1  branch/jump resolved taken in EX this cycle
irq  in  1  external interrupt request, level
int_enable  in  1  interrupt-enable flag from committed (MEM/WB) flags
pc_stall  out  1  hold PC; a branch-target load still overrides it inside the PC unit
ifid_stall  out  1  hold IF/ID contents
ifid_flush  out  1  bubble IF/ID
idex_flush  out  1  bubble ID/EX
exmem_flush  out  1  bubble EX/MEM
memwb_flush  out  1  bubble MEM/WB
push_pc  out  1  write the return PC to the stack this cycle
load_vector  out  1  load the interrupt vector into the PC this cycle
int_active  out  1  interrupt entry in progress

Behaviour:
- State register: RUN, INT_DRAIN, INT_PUSH, INT_VEC. It resets to RUN. The 3-bit drain counter resets to 0. irq_pending resets to 0.
- Outputs are combinational from state and inputs. While reset=1, every output is 0.
- load_use = idex_mem_read & ((ifid_uses_a & ifid_rs_a==idex_rd) | (ifid_uses_b & ifid_rs_b==idex_rd)).
- RUN, priority order (highest first):
  - ex_branch_taken: ifid_flush=1, idex_flush=1. A coincident load_use is ignored because it is wrong-path.
  - load_use: pc_stall=1, ifid_stall=1, idex_flush=1 for exactly one cycle. The next cycle the load is in MEM, so load_use is 0 and forwarding covers it.
  - Otherwise all outputs are 0.
- irq_pending is set on any cycle with irq=1. It is cleared on the transition into INT_PUSH, and the clear wins over a same-cycle set.
- RUN -> INT_DRAIN when irq_pending & int_enable & !ex_branch_taken & !load_use. The counter loads DRAIN_CYCLES-1.
- INT_DRAIN:
  - pc_stall=1, ifid_flush=1, int_active=1. No new instructions enter ID.
  - ex_branch_taken additionally asserts idex_flush. The branch target load proceeds, so the return address becomes the branch target.
  - The counter decrements each cycle. At 0 the state goes to INT_PUSH.
- INT_PUSH (1 cycle): push_pc=1, pc_stall=1, ifid_flush=1, int_active=1 -> INT_VEC.
- INT_VEC (1 cycle): load_vector=1, ifid_flush=1, int_active=1 -> RUN.
- exmem_flush and memwb_flush are 0 in all non-reset states. They are driven only so that a future exception path can reuse this block.
- irq re-asserted during INT_VEC sets pending again. It is accepted in RUN only once int_enable=1 (the ISR clears I in the entry sequence).
- Reset mid-sequence: the state returns to RUN next edge, pending clears, and no push_pc/load_vector is issued.

Decomposition:
- Shared package pipe_pkg: state encoding (RUN=0, INT_DRAIN=1, INT_PUSH=2, INT_VEC=3), register-index width (2), the interrupt vector address constant.
- One natural sub-module: load_use_detect, a pure comparator producing load_use.

Test Plan:
- Load-use: idex_mem_read=1, idex_rd=2, ifid_rs_a=2, uses_a=1 for 1 cycle -> pc_stall=ifid_stall=idex_flush=1 that cycle only; all 0 next cycle once idex_mem_read=0.
- No hazard: idex_rd=2, rs_a=2 but uses_a=0, uses_b=0 -> all outputs 0.
- Branch vs load-use: ex_branch_taken=1 with load_use true -> ifid_flush=idex_flush=1, pc_stall=0, ifid_stall=0.
- Interrupt entry, DRAIN_CYCLES=3: irq pulse 1 cycle, int_enable=1 -> pc_stall=1 for 3 DRAIN cycles, push_pc=1 on cycle 4, load_vector=1 on cycle 5, int_active=1 for 5 cycles, RUN on cycle 6.
- Masked interrupt: irq=1 with int_enable=0 for 10 cycles -> stays in RUN. int_enable then goes 1 -> INT_DRAIN next cycle, because pending is held.
- Reset mid-sequence: reset asserted during INT_PUSH -> all outputs 0 while reset is high, RUN afterwards, no load_vector ever pulses.
